// File: rtl/aximm2s_cmdseq.sv
// Command sequencer for an AXI memory-to-stream DMA: queues {addr, len, inc}
// commands, launches them one at a time and tracks completion, errors and aborts.
module aximm2s_cmdseq #(
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int LGLEN            = 20,
    parameter int LGQUEUE          = 2
) (
    input  logic                        S_AXI_ACLK,
    input  logic                        i_reset,
    input  logic                        i_cmd_valid,
    output logic                        o_cmd_ready,
    input  logic [C_AXI_ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [LGLEN-1:0]            i_cmd_len,
    input  logic                        i_cmd_inc,
    input  logic                        i_abort,
    input  logic                        i_clear_err,
    output logic                        o_dma_start,
    output logic [C_AXI_ADDR_WIDTH-1:0] o_dma_addr,
    output logic [LGLEN-1:0]            o_dma_len,
    output logic                        o_dma_inc,
    output logic                        o_dma_abort,
    input  logic                        i_dma_busy,
    input  logic                        i_dma_done,
    input  logic                        i_dma_err,
    output logic                        o_busy,
    output logic                        o_err,
    output logic                        o_int,
    output logic [15:0]                 o_completed,
    output logic [LGQUEUE:0]            o_fill
);
    localparam int EW    = C_AXI_ADDR_WIDTH + LGLEN + 1;
    localparam int DEPTH = 1 << LGQUEUE;
    localparam logic [LGQUEUE:0]   FILL_FULL = (LGQUEUE+1)'(DEPTH);
    localparam logic [LGQUEUE:0]   FILL_ONE  = (LGQUEUE+1)'(1);
    localparam logic [LGQUEUE:0]   FILL_ZERO = (LGQUEUE+1)'(0);
    localparam logic [LGQUEUE-1:0] PTR_ONE   = (LGQUEUE)'(1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LAUNCH   = 3'd1;
    localparam logic [2:0] S_WAIT     = 3'd2;
    localparam logic [2:0] S_ABORTING = 3'd3;
    localparam logic [2:0] S_HALT     = 3'd4;

    logic [EW-1:0]               mem_r [DEPTH];
    logic [LGQUEUE-1:0]          wr_ptr_r, rd_ptr_r;
    logic [LGQUEUE:0]            fill_r, fill_next_s;
    logic [2:0]                  state_r, state_next_s;
    logic                        push_s, pop_s, flush_s, launch_s, done_ok_s;
    logic                        int_s, int_next_s, abort_pulse_s, err_set_s, err_clr_s;
    logic                        ready_r, busy_r, start_r, abort_r, int_r, err_r, inc_r;
    logic [C_AXI_ADDR_WIDTH-1:0] addr_r;
    logic [LGLEN-1:0]            len_r;
    logic [15:0]                 completed_r;
    logic [EW-1:0]               head_s;

    assign push_s = i_cmd_valid && ready_r;
    assign head_s = mem_r[rd_ptr_r];

    // Sequencer state transitions and per-cycle control decisions
    always_comb begin
        state_next_s  = state_r;
        pop_s         = 1'b0;
        flush_s       = 1'b0;
        launch_s      = 1'b0;
        done_ok_s     = 1'b0;
        int_s         = 1'b0;
        abort_pulse_s = 1'b0;
        err_set_s     = 1'b0;
        err_clr_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                // An abort while idle only empties the queue; it also blocks a pop.
                if (i_abort) begin
                    flush_s = 1'b1;
                end else if ((fill_r != FILL_ZERO) && !i_dma_busy) begin
                    pop_s = 1'b1;
                    if (head_s[LGLEN:1] != {LGLEN{1'b0}}) begin
                        launch_s     = 1'b1;
                        state_next_s = S_LAUNCH;
                    end else begin
                        state_next_s = S_IDLE;
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_LAUNCH: begin
                if (i_abort) begin
                    flush_s       = 1'b1;
                    abort_pulse_s = 1'b1;
                    state_next_s  = S_ABORTING;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_dma_done && i_dma_err) begin
                    err_set_s    = 1'b1;
                    flush_s      = 1'b1;
                    int_s        = 1'b1;
                    state_next_s = S_HALT;
                end else if (i_dma_done) begin
                    // A done coinciding with abort is counted; the transfer is over, so no ABORTING wait.
                    done_ok_s     = 1'b1;
                    flush_s       = i_abort;
                    abort_pulse_s = i_abort;
                    state_next_s  = S_IDLE;
                end else if (i_abort) begin
                    flush_s       = 1'b1;
                    abort_pulse_s = 1'b1;
                    state_next_s  = S_ABORTING;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_ABORTING: begin
                if (i_dma_done) begin
                    int_s        = 1'b1;
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_ABORTING;
                end
            end
            S_HALT: begin
                if (i_clear_err) begin
                    err_clr_s    = 1'b1;
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_HALT;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Queue occupancy after this cycle's push, pop and flush
    always_comb begin
        fill_next_s = fill_r;
        if (flush_s) begin
            fill_next_s = FILL_ZERO;
        end else if (push_s && !pop_s) begin
            fill_next_s = fill_r + FILL_ONE;
        end else if (!push_s && pop_s) begin
            fill_next_s = fill_r - FILL_ONE;
        end else begin
            fill_next_s = fill_r;
        end
        int_next_s = int_s || (done_ok_s && (fill_next_s == FILL_ZERO));
    end

    // Command storage; a flushed push is never written
    always_ff @(posedge S_AXI_ACLK) begin
        if (push_s && !flush_s) begin
            mem_r[wr_ptr_r] <= {i_cmd_addr, i_cmd_len, i_cmd_inc};
        end
    end

    // State, queue pointers and registered status outputs
    always_ff @(posedge S_AXI_ACLK) begin
        if (i_reset) begin
            state_r     <= S_IDLE;
            wr_ptr_r    <= {LGQUEUE{1'b0}};
            rd_ptr_r    <= {LGQUEUE{1'b0}};
            fill_r      <= FILL_ZERO;
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
            int_r       <= 1'b0;
            completed_r <= 16'd0;
        end else begin
            state_r <= state_next_s;
            fill_r  <= fill_next_s;
            if (flush_s) begin
                wr_ptr_r <= {LGQUEUE{1'b0}};
                rd_ptr_r <= {LGQUEUE{1'b0}};
            end else begin
                wr_ptr_r <= push_s ? wr_ptr_r + PTR_ONE : wr_ptr_r;
                rd_ptr_r <= pop_s ? rd_ptr_r + PTR_ONE : rd_ptr_r;
            end
            ready_r <= (fill_next_s != FILL_FULL) && (state_next_s != S_HALT)
                       && (state_next_s != S_ABORTING);
            busy_r  <= (state_next_s != S_IDLE) || (fill_next_s != FILL_ZERO);
            err_r   <= err_set_s ? 1'b1 : (err_clr_s ? 1'b0 : err_r);
            int_r   <= int_next_s;
            completed_r <= done_ok_s ? completed_r + 16'd1 : completed_r;
        end
    end

    // DMA launch/abort pulses and the held launch descriptor
    always_ff @(posedge S_AXI_ACLK) begin
        if (i_reset) begin
            start_r <= 1'b0;
            abort_r <= 1'b0;
            addr_r  <= {C_AXI_ADDR_WIDTH{1'b0}};
            len_r   <= {LGLEN{1'b0}};
            inc_r   <= 1'b0;
        end else begin
            start_r <= launch_s;
            abort_r <= abort_pulse_s;
            if (launch_s) begin
                addr_r <= head_s[EW-1 -: C_AXI_ADDR_WIDTH];
                len_r  <= head_s[LGLEN:1];
                inc_r  <= head_s[0];
            end else begin
                addr_r <= addr_r;
                len_r  <= len_r;
                inc_r  <= inc_r;
            end
        end
    end

    assign o_cmd_ready = ready_r;
    assign o_dma_start = start_r;
    assign o_dma_addr  = addr_r;
    assign o_dma_len   = len_r;
    assign o_dma_inc   = inc_r;
    assign o_dma_abort = abort_r;
    assign o_busy      = busy_r;
    assign o_err       = err_r;
    assign o_int       = int_r;
    assign o_completed = completed_r;
    assign o_fill      = fill_r;
endmodule
